distribute_seq: RTL and testbench

Sequential 1-to-2 distribution node: the counterpart of the sequential reduction adder, used at each node of the distribution tree. It accepts one data word per cycle with a destination mask. It buffers the word in a per-output FIFO and presents it on the packed two-lane output bus, supporting unicast, multicast and independent downstream back-pressure. The lane packing matches the reduction side: lane 0 is the low half, lane 1 the high half.

---
 rtl/distribute_seq.sv | 78 +++++++
 tb/tb_distribute_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/distribute_seq.sv
`default_nettype none
// ============================================================================
// Module      : distribute_seq
// Description : Sequential 1-to-2 distribution node with one FIFO per output
//               lane, unicast/multicast push and independent lane back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module distribute_seq #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data_bus,
    input  logic [1:0]              i_dest,
    output logic                    o_ready,
    output logic [1:0]              o_valid,
    output logic [2*DATA_WIDTH-1:0] o_data_bus,
    input  logic [1:0]              i_ready
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    logic [1:0] w_full;
    logic [1:0] w_push;
    logic [1:0] w_pop;

    // Acceptance looks only at registered occupancy, so a lane popping this
    // cycle still refuses a new word while it is full.
    assign o_ready = i_en & ~rst & ~|(i_dest & w_full);
    assign w_push  = {2{i_valid & o_ready}} & i_dest;
    assign w_pop   = o_valid & i_ready;

    for (genvar k = 0; k < 2; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0]    r_rd_ptr;
        logic [c_PTR_W-1:0]    r_wr_ptr;
        logic [c_CNT_W-1:0]    r_count;

        assign w_full[k]  = (r_count == c_FULL);
        assign o_valid[k] = i_en & (r_count != '0);
        assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] =
            o_valid[k] ? r_mem[r_rd_ptr] : '0;

        // Storage is not reset; occupancy alone decides what is visible.
        always_ff @(posedge clk) begin
            if (w_push[k]) begin
                r_mem[r_wr_ptr] <= i_data_bus;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[k]) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[k]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_distribute_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_distribute_seq
// Description : Self-checking bench for distribute_seq: directed vector table
//               followed by a queue-scoreboard random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distribute_seq;

    logic       clk;
    logic       rst;
    logic       i_en;
    logic       i_valid;
    logic [3:0] i_data_bus;
    logic [1:0] i_dest;
    logic       o_ready;
    logic [1:0] o_valid;
    logic [7:0] o_data_bus;
    logic [1:0] i_ready;

    int n_tests = 0;
    int n_fail  = 0;

    distribute_seq #(.DATA_WIDTH(4), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_dest     (i_dest),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .i_ready    (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       e;
        logic       v;
        logic [3:0] d;
        logic [1:0] dst;
        logic [1:0] rdy;
        logic       exp_rdy;
        logic [1:0] exp_v;
        logic [7:0] exp_d;
        logic       chk_out;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic v,
                                input logic [3:0] d, input logic [1:0] dst,
                                input logic [1:0] rdy, input logic exp_rdy,
                                input logic [1:0] exp_v, input logic [7:0] exp_d,
                                input logic chk_out);
        vec_t t;
        t.r = r; t.e = e; t.v = v; t.d = d; t.dst = dst; t.rdy = rdy;
        t.exp_rdy = exp_rdy; t.exp_v = exp_v; t.exp_d = exp_d; t.chk_out = chk_out;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [3:0] d,
                         input logic [1:0] dst, input logic [1:0] rdy);
        rst = r; i_en = e; i_valid = v; i_data_bus = d; i_dest = dst; i_ready = rdy;
    endtask

    logic [3:0] q0[$];
    logic [3:0] q1[$];

    initial begin
        //  rst en v  data  dest   rdy    | ready valid  data   chk
        add(1, 1, 1, 4'hF, 2'b11, 2'b11,   0, 2'b00, 8'h00, 1); // reset, 2nd cycle
        add(0, 1, 1, 4'h3, 2'b01, 2'b11,   1, 2'b00, 8'h00, 1); // unicast lane 0
        add(0, 1, 1, 4'hA, 2'b10, 2'b11,   1, 2'b01, 8'h03, 1); // unicast lane 1
        add(0, 1, 0, 4'h0, 2'b00, 2'b11,   1, 2'b10, 8'hA0, 1);
        add(0, 1, 0, 4'h0, 2'b00, 2'b11,   1, 2'b00, 8'h00, 1);
        add(0, 1, 1, 4'h5, 2'b11, 2'b01,   1, 2'b00, 8'h00, 1); // multicast, lane 1 stalled
        add(0, 1, 1, 4'h6, 2'b11, 2'b01,   1, 2'b11, 8'h55, 1);
        add(0, 1, 1, 4'h7, 2'b11, 2'b01,   0, 2'b11, 8'h56, 1); // lane 1 full
        add(0, 1, 1, 4'h7, 2'b11, 2'b01,   0, 2'b10, 8'h50, 1);
        add(0, 1, 1, 4'h7, 2'b11, 2'b11,   0, 2'b10, 8'h50, 1); // full blocks despite pop
        add(0, 1, 1, 4'h7, 2'b11, 2'b11,   1, 2'b10, 8'h60, 1);
        add(0, 1, 0, 4'h0, 2'b00, 2'b11,   1, 2'b11, 8'h77, 1);
        add(0, 1, 0, 4'h0, 2'b00, 2'b11,   1, 2'b00, 8'h00, 1);
        add(0, 1, 1, 4'h8, 2'b10, 2'b00,   1, 2'b00, 8'h00, 1); // fill lane 1
        add(0, 1, 1, 4'h9, 2'b10, 2'b00,   1, 2'b10, 8'h80, 1);
        add(0, 1, 1, 4'h1, 2'b01, 2'b01,   1, 2'b10, 8'h80, 1); // stream lane 0
        add(0, 1, 1, 4'h2, 2'b01, 2'b01,   1, 2'b11, 8'h81, 1);
        add(0, 1, 1, 4'h3, 2'b01, 2'b01,   1, 2'b11, 8'h82, 1);
        add(0, 1, 1, 4'h4, 2'b01, 2'b01,   1, 2'b11, 8'h83, 1);
        add(0, 1, 1, 4'hC, 2'b10, 2'b01,   0, 2'b11, 8'h84, 1);
        add(0, 1, 0, 4'h0, 2'b00, 2'b11,   1, 2'b10, 8'h80, 1);
        add(0, 1, 0, 4'h0, 2'b00, 2'b11,   1, 2'b10, 8'h90, 1);
        add(0, 1, 1, 4'h1, 2'b01, 2'b00,   1, 2'b00, 8'h00, 1); // fill lane 0
        add(0, 1, 1, 4'h2, 2'b01, 2'b00,   1, 2'b01, 8'h01, 1);
        add(0, 1, 1, 4'h3, 2'b01, 2'b01,   0, 2'b01, 8'h01, 1); // full: pop only
        add(0, 1, 1, 4'h3, 2'b01, 2'b01,   1, 2'b01, 8'h02, 1); // count 1: push+pop
        add(0, 1, 1, 4'h4, 2'b01, 2'b01,   1, 2'b01, 8'h03, 1);
        add(0, 1, 1, 4'h9, 2'b01, 2'b01,   1, 2'b01, 8'h04, 1);
        add(0, 0, 1, 4'hE, 2'b11, 2'b11,   0, 2'b00, 8'h00, 1); // disabled, 9 held
        add(0, 0, 0, 4'h0, 2'b00, 2'b11,   0, 2'b00, 8'h00, 1);
        add(0, 1, 1, 4'hB, 2'b10, 2'b00,   1, 2'b01, 8'h09, 1);
        add(1, 1, 1, 4'hC, 2'b11, 2'b00,   0, 2'b00, 8'h00, 0); // reset flush
        add(0, 1, 0, 4'h0, 2'b00, 2'b11,   1, 2'b00, 8'h00, 1);
        add(0, 1, 0, 4'h0, 2'b00, 2'b11,   1, 2'b00, 8'h00, 1);
        add(0, 1, 1, 4'hD, 2'b11, 2'b11,   1, 2'b00, 8'h00, 1);
        add(0, 1, 0, 4'h0, 2'b00, 2'b11,   1, 2'b11, 8'hDD, 1);
        add(0, 1, 1, 4'hF, 2'b00, 2'b00,   1, 2'b00, 8'h00, 1); // dest 00 discarded
        add(0, 1, 0, 4'h0, 2'b00, 2'b00,   1, 2'b00, 8'h00, 1);

        drive(1, 1, 1, 4'hF, 2'b11, 2'b11);
        #4;
        check("reset_ready_first", {7'd0, o_ready}, 8'h00);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].d, vecs[i].dst, vecs[i].rdy);
            #4;
            check($sformatf("vec%0d_ready", i), {7'd0, o_ready}, {7'd0, vecs[i].exp_rdy});
            if (vecs[i].chk_out) begin
                check($sformatf("vec%0d_valid", i), {6'd0, o_valid}, {6'd0, vecs[i].exp_v});
                check($sformatf("vec%0d_data", i), o_data_bus, vecs[i].exp_d);
            end
            @(posedge clk); #1;
        end

        // Random phase: all lanes empty here; the queues track expected contents.
        for (int c = 0; c < 400; c++) begin
            logic       e, v, erdy;
            logic [3:0] d;
            logic [1:0] dst, rdy, ev;
            logic [7:0] ed;
            e   = ($urandom_range(0, 9) != 0);
            v   = $urandom_range(0, 1);
            d   = 4'($urandom);
            dst = 2'($urandom);
            rdy = 2'($urandom);
            drive(0, e, v, d, dst, rdy);
            erdy = e & !(dst[0] && q0.size() >= 2) & !(dst[1] && q1.size() >= 2);
            ev   = {e && q1.size() != 0, e && q0.size() != 0};
            ed   = {ev[1] ? q1[0] : 4'h0, ev[0] ? q0[0] : 4'h0};
            #4;
            check($sformatf("rnd%0d_ready", c), {7'd0, o_ready}, {7'd0, erdy});
            check($sformatf("rnd%0d_valid", c), {6'd0, o_valid}, {6'd0, ev});
            check($sformatf("rnd%0d_data", c), o_data_bus, ed);
            @(posedge clk); #1;
            if (ev[0] && rdy[0]) void'(q0.pop_front());
            if (ev[1] && rdy[1]) void'(q1.pop_front());
            if (v && erdy && dst[0]) q0.push_back(d);
            if (v && erdy && dst[1]) q1.push_back(d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
